uart_frame_sender: RTL and testbench

UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

---
 rtl/uart_frame_sender_pkg.sv | 19 +
 rtl/uart_frame_sender_if.sv | 25 ++
 rtl/uart_frame_sender.sv | 106 ++++++++++
 tb/tb_uart_frame_sender.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_sender_pkg.sv
// Shared definitions for the UART frame sender: FSM encoding, default header
// byte and frame-length helper.
package uart_frame_sender_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Header + data bytes + checksum byte.
    function automatic int frame_len(input int nbytes);
        return nbytes + 2;
    endfunction

endpackage

// File: rtl/uart_frame_sender_if.sv
// Word-in / UART-byte-out handshake bundle of the frame sender.
interface uart_frame_sender_if #(
    parameter int NBYTES = 4
);
    logic                  word_valid;
    logic [8*NBYTES-1:0]   word_in;
    logic                  word_ready;
    logic                  tx_start;
    logic [7:0]            din;
    logic                  tx_done;
    logic                  busy;
    logic                  frame_done;

    // master: the frame sender itself
    modport master (
        input  word_valid, word_in, tx_done,
        output word_ready, tx_start, din, busy, frame_done
    );

    // slave: upstream word source plus the UART transmitter
    modport slave (
        output word_valid, word_in, tx_done,
        input  word_ready, tx_start, din, busy, frame_done
    );
endinterface

// File: rtl/uart_frame_sender.sv
// Serialises one word into a UART frame: HEADER, data bytes MSB first, then
// the XOR checksum, issuing one tx_start per byte and waiting for tx_done.
module uart_frame_sender
    import uart_frame_sender_pkg::*;
#(
    parameter int         NBYTES = 4,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic               clk,
    input  logic               reset,
    uart_frame_sender_if.master bus
);

    localparam logic [2:0] LAST_IDX = 3'(frame_len(NBYTES) - 1);

    state_t              state, state_next;
    logic [2:0]          idx;
    logic [2:0]          idx_inc;
    logic [8*NBYTES-1:0] word_q;
    logic [7:0]          chk_q;
    logic [7:0]          din_q;
    logic [7:0]          word_chk;
    logic [7:0]          next_byte;
    logic                accept;
    logic                word_ready, tx_start, busy, frame_done;

    assign idx_inc = idx + 3'd1;
    assign accept  = (state == IDLE) && bus.word_valid;

    always_comb begin
        word_chk = 8'h00;
        for (int b = 0; b < NBYTES; b++)
            word_chk = word_chk ^ bus.word_in[8*b +: 8];
    end

    // Byte at idx+1: data bytes MSB first, checksum after the last one.
    always_comb begin
        next_byte = chk_q;
        for (int b = 1; b <= NBYTES; b++)
            if (idx_inc == 3'(b))
                next_byte = word_q[8*(NBYTES-b) +: 8];
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        word_ready = 1'b0;
        tx_start   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                word_ready = !reset;
                if (bus.word_valid) state_next = ISSUE;
            end
            ISSUE: begin
                tx_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) state_next = (idx == LAST_IDX) ? DONE : ISSUE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
            din_q <= 8'h00;
        end else begin
            state <= state_next;
            if (accept) begin
                idx   <= 3'd0;
                din_q <= HEADER;
            end else if (state == WAIT && bus.tx_done && idx != LAST_IDX) begin
                idx   <= idx_inc;
                din_q <= next_byte;
            end
        end
    end

    // NOTE: word and checksum carry no reset; they are only read after a fresh
    // accept reloads them, so a reset discards them by returning to IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= bus.word_in;
            chk_q  <= word_chk;
        end
    end

    assign bus.word_ready = word_ready;
    assign bus.tx_start   = tx_start;
    assign bus.din        = din_q;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Randomised bench for uart_frame_sender: a UART transmitter model answers
// each tx_start with a delayed tx_done; byte streams are compared to a model.
module tb_uart_frame_sender;

    localparam int         NB  = 4;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_frame_sender_if #(.NBYTES(NB)) ifc ();

    uart_frame_sender #(.NBYTES(NB), .HEADER(HDR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Transmitter model: random 1..4 cycle byte time, shares the reset.
    logic model_done = 1'b0, issue_spur = 1'b0, idle_spur = 1'b0, inject_issue = 1'b0;
    int   pend = 0;
    assign ifc.tx_done = model_done | issue_spur | idle_spur;

    always @(posedge clk) begin
        #2;
        model_done = 1'b0;
        issue_spur = 1'b0;
        if (reset) pend = 0;
        else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) model_done = 1'b1;
            end
            if (ifc.tx_start) begin
                pend       = $urandom_range(1, 4);
                issue_spur = inject_issue;
            end
        end
    end

    // Monitor and protocol checks, sampled mid-cycle.
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int cyc = 0, n_start = 0, n_fd = 0, n_acc = 0, acc_cycle = 0, fd_cycle = 0, viol = 0;
    logic prev_trig = 1'b0, prev_done = 1'b0, prev_start = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (ifc.tx_start) begin
                obs_q.push_back(ifc.din);
                n_start++;
                check("start_lat", {30'd0, prev_start, prev_trig}, 32'd1);
            end
            if (ifc.frame_done) begin
                n_fd++;
                fd_cycle = cyc;
                check("fd_lat", prev_done, 1);
            end
            if (ifc.word_valid && ifc.word_ready) begin
                n_acc++;
                acc_cycle = cyc;
            end
            if (ifc.busy && ifc.word_ready) viol++;
            prev_trig  = (ifc.word_valid && ifc.word_ready) || ifc.tx_done;
            prev_done  = ifc.tx_done;
            prev_start = ifc.tx_start;
        end else begin
            prev_trig  = 1'b0;
            prev_done  = 1'b0;
            prev_start = 1'b0;
        end
    end

    function automatic void push_expected(input logic [8*NB-1:0] w);
        logic [7:0] c;
        c = 8'h00;
        exp_q.push_back(HDR);
        for (int b = NB - 1; b >= 0; b--) begin
            exp_q.push_back(w[8*b +: 8]);
            c = c ^ w[8*b +: 8];
        end
        exp_q.push_back(c);
    endfunction

    task automatic clear_all();
        obs_q.delete();
        exp_q.delete();
        n_start = 0;
        n_fd    = 0;
        n_acc   = 0;
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    // which: 0 = accepts, 1 = tx_starts, 2 = frame_dones
    task automatic wait_count(input string tag, input int which, input int target);
        int cur;
        cur = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            cur = (which == 0) ? n_acc : (which == 1) ? n_start : n_fd;
            if (cur >= target) break;
        end
        check({tag, "_reached"}, cur >= target, 1);
    endtask

    task automatic send_word(input string tag, input logic [8*NB-1:0] w);
        @(posedge clk);
        #1;
        ifc.word_valid = 1'b1;
        ifc.word_in    = w;
        wait_count(tag, 0, n_acc + 1);
        @(posedge clk);
        #1;
        ifc.word_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*NB-1:0] w;
        reset          = 1'b1;
        ifc.word_valid = 1'b0;
        ifc.word_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", ifc.busy, 0);
        check("rst_tx_start", ifc.tx_start, 0);
        check("rst_frame_done", ifc.frame_done, 0);
        check("rst_din", ifc.din, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ifc.word_ready, 1);

        // Basic frame with known checksum 08.
        clear_all();
        push_expected(32'h12345678);
        send_word("s1", 32'h12345678);
        wait_count("s1_frame", 2, 1);
        repeat (3) @(negedge clk);
        compare_stream("s1");
        check("s1_starts", n_start, 6);
        check("s1_fd", n_fd, 1);

        // All-zero word.
        clear_all();
        push_expected(32'h00000000);
        send_word("s2", 32'h00000000);
        wait_count("s2_frame", 2, 1);
        compare_stream("s2");

        // word_valid held: back-to-back frames, second accept right after frame_done.
        clear_all();
        push_expected(32'hFFFFFFFF);
        push_expected(32'h01020304);
        @(posedge clk);
        #1;
        ifc.word_valid = 1'b1;
        ifc.word_in    = 32'hFFFFFFFF;
        wait_count("s3_acc1", 0, 1);
        @(posedge clk);
        #1 ifc.word_in = 32'h01020304;
        wait_count("s3_frame1", 2, 1);
        wait_count("s3_acc2", 0, 2);
        check("s3_b2b_gap", acc_cycle - fd_cycle, 1);
        @(posedge clk);
        #1 ifc.word_valid = 1'b0;
        wait_count("s3_frame2", 2, 2);
        compare_stream("s3");

        // word_valid while busy with a different word is ignored.
        clear_all();
        push_expected(32'hDEADBEEF);
        @(posedge clk);
        #1;
        ifc.word_valid = 1'b1;
        ifc.word_in    = 32'hDEADBEEF;
        wait_count("s4_acc", 0, 1);
        @(posedge clk);
        #1 ifc.word_in = 32'h11223344;
        repeat (4) @(posedge clk);
        #1 ifc.word_valid = 1'b0;
        wait_count("s4_frame", 2, 1);
        repeat (5) @(negedge clk);
        check("s4_acc_count", n_acc, 1);
        compare_stream("s4");

        // Spurious tx_done in IDLE, then on every ISSUE cycle of a frame.
        clear_all();
        @(posedge clk);
        #1 idle_spur = 1'b1;
        @(posedge clk);
        #1 idle_spur = 1'b0;
        @(negedge clk);
        check("s5_idle_busy", ifc.busy, 0);
        check("s5_idle_ready", ifc.word_ready, 1);
        check("s5_idle_starts", n_start, 0);
        push_expected(32'h5A0FF0C3);
        inject_issue = 1'b1;
        send_word("s5", 32'h5A0FF0C3);
        wait_count("s5_frame", 2, 1);
        inject_issue = 1'b0;
        compare_stream("s5");

        // Reset during WAIT of byte index 3 abandons the frame.
        clear_all();
        send_word("s6", 32'hCAFEF00D);
        wait_count("s6_start4", 1, 4);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("s6_ready_after", ifc.word_ready, 1);
        check("s6_busy_after", ifc.busy, 0);
        repeat (20) @(negedge clk);
        check("s6_no_more_start", n_start, 4);
        check("s6_no_fd", n_fd, 0);
        clear_all();
        push_expected(32'h89ABCDEF);
        send_word("s6b", 32'h89ABCDEF);
        wait_count("s6b_frame", 2, 1);
        compare_stream("s6b");

        // Reset in the same cycle as a would-be accept drops the word.
        clear_all();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        ifc.word_valid = 1'b1;
        ifc.word_in    = 32'h77777777;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        ifc.word_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("s7_no_start", n_start, 0);
        check("s7_no_fd", n_fd, 0);

        // Random words with random gaps and transmitter timing.
        clear_all();
        for (int k = 0; k < 12; k++) begin
            w = $urandom;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            push_expected(w);
            send_word($sformatf("rnd%0d", k), w);
            wait_count($sformatf("rnd%0d_frame", k), 2, k + 1);
        end
        compare_stream("rnd");
        check("rnd_starts", n_start, 12 * (NB + 2));

        check("busy_ready_excl", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
